sram_ctrl_burst: RTL and testbench
==================================

Name: sram_ctrl_burst

Overview:
Parametrised async-SRAM controller and successor to the fixed 21-bit/16-bit single-access controller. It has configurable address and data widths, per-byte write enables, programmable access timing, and sequential bursts of 1..2^LEN_W words. A command/ready handshake and per-word write-data handshake sit on the user side. On the device side it drives a properly tri-stated data bus and active-low CS/OE/WE/byte-enable pins.

Parameters:
ADDR_W, 21, SRAM address width; burst addresses wrap modulo 2^ADDR_W.
DATA_W, 16, data width; must be a multiple of 8. BE_W = DATA_W/8 is derived.
LEN_W, 4, burst length field width; words per burst = i_cmd_len+1.
POWERUP_CYC, 40000, clock cycles of power-up wait after reset release (200 us at 200 MHz); >=1.
RD_CYC, 3, cycles each read word is held before sampling; >=1.
WR_CYC, 3, WE-low pulse width in cycles; >=1.
TURN_CYC, 1, idle cycles with all controls high and bus released after every command; >=1.

Ports:
i_clk  in  1  clock.
reset  in  1  asynchronous, active-low reset.
i_cmd_valid  in  1  command request.
o_cmd_ready  out  1  controller can accept a command.
i_cmd_wr  in  1  1 = write, 0 = read.
i_cmd_addr  in  ADDR_W  start word address.
i_cmd_len  in  LEN_W  burst length minus one.
i_cmd_be  in  BE_W  active-high byte enables for writes; ignored for reads.
i_wr_data  in  DATA_W  write word.
i_wr_valid  in  1  write word present.
o_wr_ready  out  1  write word accepted when high together with i_wr_valid.
o_wr_done  out  1  one-cycle pulse when the last word of a write burst completes.
o_rd_data  out  DATA_W  read word.
o_rd_valid  out  1  one-cycle pulse per read word.
o_busy  out  1  high in every state except IDLE.
o_sram_addr  out  ADDR_W  device address.
io_sram_dq  inout  DATA_W  device data bus.
o_sram_cs_n  out  1  chip select.
o_sram_oe_n  out  1  output enable.
o_sram_we_n  out  1  write enable.
o_sram_be_n  out  BE_W  byte enables; bit0 = LB.

Behaviour:
- Reset (async, immediate, any state):
  - cs_n, oe_n, we_n and all be_n bits = 1; o_sram_addr = 0; io_sram_dq = Z.
  - o_cmd_ready, o_wr_ready, o_rd_valid, o_wr_done = 0; o_rd_data = 0; o_busy = 1.
  - State = INIT. Any in-flight burst is abandoned; no partial word completes.
- INIT: counts POWERUP_CYC rising edges after reset release, then goes to IDLE.
- IDLE: o_cmd_ready=1, o_busy=0. A command handshake at edge E0 latches addr, len, be and wr.
  - Read: go to RD_ACC.
  - Write: go to WR_DATA.
- RD_ACC:
  - From E0: cs_n=0, oe_n=0, all be_n=0, we_n=1, address driven.
  - Word k is sampled from io_sram_dq at edge E0+(k+1)*RD_CYC; o_rd_data/o_rd_valid show it in the following cycle.
  - The address increments at each sample edge; cs_n/oe_n stay low across the burst.
  - After the last sample, go to TURN.
  - There is no backpressure on read data.
- WR_DATA: o_wr_ready=1, cs_n=0, we_n=1. A data handshake latches the word and goes to WR_SETUP. If i_wr_valid stays low, the controller waits indefinitely with we_n high.
- WR_SETUP (1 cycle): address and data driven, we_n=1.
- WR_PULSE (WR_CYC cycles): we_n=0, be_n = ~latched be.
- WR_HOLD (1 cycle): we_n=1, data still driven. Then:
  - More words: address+1, back to WR_DATA.
  - Last word: o_wr_done pulses, go to TURN.
- Bus drive: io_sram_dq is driven only in WR_SETUP, WR_PULSE and WR_HOLD; Z everywhere else. oe_n=1 in all write states.
- TURN (TURN_CYC cycles): all controls high, bus Z, o_busy=1, then IDLE.
- Handshake rules:
  - A command presented while o_cmd_ready=0 is ignored (stall, not dropped); the user holds it.
  - i_wr_valid outside WR_DATA is ignored.
- Boundaries:
  - len=0 gives a single access.
  - Address 2^ADDR_W-1 increments to 0.
  - be=0 still runs the write timing with all be_n high, so no bytes change.

Test Plan:
1. POWERUP_CYC=8, release reset -> o_cmd_ready stays 0 for 8 edges then goes 1; all controls stay high and the bus stays Z throughout.
2. Write 0xA55A to 0x1ABCD with be=2'b11, then read the same address (RD_CYC=3) -> model holds 0xA55A; o_rd_valid pulses the cycle after E0+3 with o_rd_data=0xA55A; o_wr_done pulses exactly once.
3. Model word = 0xFFFF, write 0x1234 with be=2'b01 -> model = 0xFF34; be_n=2'b10 only during the WE pulse; we_n is low for exactly 3 cycles.
4. Burst read len=3 at 0x1FFFFE -> addresses 1FFFFE, 1FFFFF, 000000, 000001 in turn; 4 o_rd_valid pulses spaced 3 cycles apart; cs_n continuously low.
5. Burst write len=1 with i_wr_valid dropped for 5 cycles between words -> we_n held high and cs_n low during the gap; no spurious model write; a single o_wr_done after word 2.
6. Assert reset in the 2nd WR_PULSE cycle -> same cycle, we_n/cs_n go 1 and the bus goes Z; model word unchanged or fully written (never X); controller re-runs INIT.

Source files
------------

// File: rtl/sram_ctrl_burst_if.sv
// User-side command, write-data and read-data handshake bundle for
// sram_ctrl_burst; slave = controller side, master = user side.
interface sram_ctrl_burst_if #(
  parameter int ADDR_W = 21,
  parameter int DATA_W = 16,
  parameter int LEN_W  = 4
);
  logic                  i_cmd_valid;
  logic                  o_cmd_ready;
  logic                  i_cmd_wr;
  logic [ADDR_W-1:0]     i_cmd_addr;
  logic [LEN_W-1:0]      i_cmd_len;
  logic [DATA_W/8-1:0]   i_cmd_be;
  logic [DATA_W-1:0]     i_wr_data;
  logic                  i_wr_valid;
  logic                  o_wr_ready;
  logic                  o_wr_done;
  logic [DATA_W-1:0]     o_rd_data;
  logic                  o_rd_valid;
  logic                  o_busy;

  modport slave (
    input  i_cmd_valid, i_cmd_wr, i_cmd_addr, i_cmd_len, i_cmd_be,
    input  i_wr_data, i_wr_valid,
    output o_cmd_ready, o_wr_ready, o_wr_done, o_rd_data, o_rd_valid, o_busy
  );

  modport master (
    output i_cmd_valid, i_cmd_wr, i_cmd_addr, i_cmd_len, i_cmd_be,
    output i_wr_data, i_wr_valid,
    input  o_cmd_ready, o_wr_ready, o_wr_done, o_rd_data, o_rd_valid, o_busy
  );
endinterface

// File: rtl/sram_ctrl_burst.sv
// Async-SRAM controller: per-byte writes, programmable read/write/turnaround
// timing and sequential bursts of 1..2^LEN_W words with address wrap.
module sram_ctrl_burst #(
  parameter int ADDR_W      = 21,
  parameter int DATA_W      = 16,
  parameter int LEN_W       = 4,
  parameter int POWERUP_CYC = 40000,
  parameter int RD_CYC      = 3,
  parameter int WR_CYC      = 3,
  parameter int TURN_CYC    = 1
) (
  input  logic                 i_clk,
  input  logic                 reset,
  sram_ctrl_burst_if.slave     bus,
  output logic [ADDR_W-1:0]    o_sram_addr,
  inout  wire  [DATA_W-1:0]    io_sram_dq,
  output logic                 o_sram_cs_n,
  output logic                 o_sram_oe_n,
  output logic                 o_sram_we_n,
  output logic [DATA_W/8-1:0]  o_sram_be_n
);
  localparam int BE_W = DATA_W / 8;

  function automatic int max_of(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  localparam int MAX_CYC = max_of(max_of(POWERUP_CYC, RD_CYC), max_of(WR_CYC, TURN_CYC));
  localparam int CNT_W   = $clog2(MAX_CYC + 1);

  localparam logic [CNT_W-1:0] PU_LAST   = CNT_W'(POWERUP_CYC - 1);
  localparam logic [CNT_W-1:0] RD_LAST   = CNT_W'(RD_CYC - 1);
  localparam logic [CNT_W-1:0] WR_LAST   = CNT_W'(WR_CYC - 1);
  localparam logic [CNT_W-1:0] TURN_LAST = CNT_W'(TURN_CYC - 1);
  localparam logic [CNT_W-1:0] CNT_ZERO  = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);
  localparam logic [LEN_W-1:0]  LEN_ZERO = {LEN_W{1'b0}};
  localparam logic [LEN_W-1:0]  LEN_ONE  = LEN_W'(1);

  typedef enum logic [2:0] {
    ST_INIT     = 3'd0,
    ST_IDLE     = 3'd1,
    ST_RD_ACC   = 3'd2,
    ST_WR_DATA  = 3'd3,
    ST_WR_SETUP = 3'd4,
    ST_WR_PULSE = 3'd5,
    ST_WR_HOLD  = 3'd6,
    ST_TURN     = 3'd7
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [CNT_W-1:0]    r_cnt;
  logic [CNT_W-1:0]    w_cnt_nxt;
  logic [ADDR_W-1:0]   r_addr;
  logic [ADDR_W-1:0]   w_addr_nxt;
  logic [LEN_W-1:0]    r_left;
  logic [LEN_W-1:0]    w_left_nxt;
  logic [BE_W-1:0]     r_be;
  logic [DATA_W-1:0]   r_wdata;
  logic [DATA_W-1:0]   r_rd_data;
  logic                r_rd_valid;
  logic                r_wr_done;
  logic                r_cmd_ready;
  logic                r_wr_ready;
  logic                r_busy;
  logic                r_cs_n;
  logic                r_oe_n;
  logic                r_we_n;
  logic [BE_W-1:0]     r_be_n;
  logic                r_dq_oe;
  logic                w_cmd_acc;
  logic                w_wr_acc;
  logic                w_sample;
  logic                w_done;
  logic                w_cs_n;
  logic                w_oe_n;
  logic                w_we_n;
  logic [BE_W-1:0]     w_be_n;
  logic                w_dq_oe;

  // State register
  always_ff @(posedge i_clk or negedge reset) begin
    if (!reset) begin
      r_state <= ST_INIT;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state, counters, and pin values for the state being entered
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_addr_nxt  = r_addr;
    w_left_nxt  = r_left;
    w_cmd_acc   = 1'b0;
    w_wr_acc    = 1'b0;
    w_sample    = 1'b0;
    w_done      = 1'b0;
    case (r_state)
      ST_INIT: begin
        if (r_cnt == PU_LAST) begin
          w_state_nxt = ST_IDLE;
          w_cnt_nxt   = CNT_ZERO;
        end else begin
          w_cnt_nxt = r_cnt + CNT_ONE;
        end
      end
      ST_IDLE: begin
        if (bus.i_cmd_valid) begin
          w_cmd_acc   = 1'b1;
          w_addr_nxt  = bus.i_cmd_addr;
          w_left_nxt  = bus.i_cmd_len;
          w_cnt_nxt   = CNT_ZERO;
          w_state_nxt = bus.i_cmd_wr ? ST_WR_DATA : ST_RD_ACC;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_RD_ACC: begin
        if (r_cnt == RD_LAST) begin
          w_sample   = 1'b1;
          w_cnt_nxt  = CNT_ZERO;
          w_addr_nxt = r_addr + ADDR_ONE;
          if (r_left == LEN_ZERO) begin
            w_state_nxt = ST_TURN;
          end else begin
            w_left_nxt = r_left - LEN_ONE;
          end
        end else begin
          w_cnt_nxt = r_cnt + CNT_ONE;
        end
      end
      ST_WR_DATA: begin
        if (bus.i_wr_valid) begin
          w_wr_acc    = 1'b1;
          w_state_nxt = ST_WR_SETUP;
        end else begin
          w_state_nxt = ST_WR_DATA;
        end
      end
      ST_WR_SETUP: begin
        w_state_nxt = ST_WR_PULSE;
        w_cnt_nxt   = CNT_ZERO;
      end
      ST_WR_PULSE: begin
        if (r_cnt == WR_LAST) begin
          w_state_nxt = ST_WR_HOLD;
          w_cnt_nxt   = CNT_ZERO;
        end else begin
          w_cnt_nxt = r_cnt + CNT_ONE;
        end
      end
      ST_WR_HOLD: begin
        if (r_left == LEN_ZERO) begin
          w_done      = 1'b1;
          w_state_nxt = ST_TURN;
          w_cnt_nxt   = CNT_ZERO;
        end else begin
          w_addr_nxt  = r_addr + ADDR_ONE;
          w_left_nxt  = r_left - LEN_ONE;
          w_state_nxt = ST_WR_DATA;
        end
      end
      ST_TURN: begin
        if (r_cnt == TURN_LAST) begin
          w_state_nxt = ST_IDLE;
          w_cnt_nxt   = CNT_ZERO;
        end else begin
          w_cnt_nxt = r_cnt + CNT_ONE;
        end
      end
      default: begin
        w_state_nxt = ST_INIT;
        w_cnt_nxt   = CNT_ZERO;
      end
    endcase

    // Pins are registered, so they are decoded from the state about to be entered
    w_cs_n  = 1'b1;
    w_oe_n  = 1'b1;
    w_we_n  = 1'b1;
    w_be_n  = {BE_W{1'b1}};
    w_dq_oe = 1'b0;
    case (w_state_nxt)
      ST_RD_ACC: begin
        w_cs_n = 1'b0;
        w_oe_n = 1'b0;
        w_be_n = {BE_W{1'b0}};
      end
      ST_WR_DATA: begin
        w_cs_n = 1'b0;
      end
      ST_WR_SETUP, ST_WR_HOLD: begin
        w_cs_n  = 1'b0;
        w_dq_oe = 1'b1;
      end
      ST_WR_PULSE: begin
        w_cs_n  = 1'b0;
        w_we_n  = 1'b0;
        w_be_n  = ~r_be;
        w_dq_oe = 1'b1;
      end
      default: begin
        w_cs_n = 1'b1;
      end
    endcase
  end

  // Datapath, handshake strobes and registered pin drivers
  always_ff @(posedge i_clk or negedge reset) begin
    if (!reset) begin
      r_cnt       <= CNT_ZERO;
      r_addr      <= {ADDR_W{1'b0}};
      r_left      <= LEN_ZERO;
      r_be        <= {BE_W{1'b0}};
      r_wdata     <= {DATA_W{1'b0}};
      r_rd_data   <= {DATA_W{1'b0}};
      r_rd_valid  <= 1'b0;
      r_wr_done   <= 1'b0;
      r_cmd_ready <= 1'b0;
      r_wr_ready  <= 1'b0;
      r_busy      <= 1'b1;
      r_cs_n      <= 1'b1;
      r_oe_n      <= 1'b1;
      r_we_n      <= 1'b1;
      r_be_n      <= {BE_W{1'b1}};
      r_dq_oe     <= 1'b0;
    end else begin
      r_cnt       <= w_cnt_nxt;
      r_addr      <= w_addr_nxt;
      r_left      <= w_left_nxt;
      r_rd_valid  <= w_sample;
      r_wr_done   <= w_done;
      r_cmd_ready <= (w_state_nxt == ST_IDLE);
      r_wr_ready  <= (w_state_nxt == ST_WR_DATA);
      r_busy      <= (w_state_nxt != ST_IDLE);
      r_cs_n      <= w_cs_n;
      r_oe_n      <= w_oe_n;
      r_we_n      <= w_we_n;
      r_be_n      <= w_be_n;
      r_dq_oe     <= w_dq_oe;
      if (w_cmd_acc) begin
        r_be <= bus.i_cmd_be;
      end
      if (w_wr_acc) begin
        r_wdata <= bus.i_wr_data;
      end
      if (w_sample) begin
        r_rd_data <= io_sram_dq;
      end
    end
  end

  assign bus.o_cmd_ready = r_cmd_ready;
  assign bus.o_wr_ready  = r_wr_ready;
  assign bus.o_wr_done   = r_wr_done;
  assign bus.o_rd_data   = r_rd_data;
  assign bus.o_rd_valid  = r_rd_valid;
  assign bus.o_busy      = r_busy;

  assign o_sram_addr = r_addr;
  assign o_sram_cs_n = r_cs_n;
  assign o_sram_oe_n = r_oe_n;
  assign o_sram_we_n = r_we_n;
  assign o_sram_be_n = r_be_n;
  assign io_sram_dq  = r_dq_oe ? r_wdata : {DATA_W{1'bz}};
endmodule

// File: tb/tb_sram_ctrl_burst.sv
// Directed bench for sram_ctrl_burst with a byte-masked async-SRAM model;
// the released data bus is pulled low so a driven bus is distinguishable.
module tb_sram_ctrl_burst;
  localparam int AW = 21;
  localparam int DW = 16;
  localparam int LW = 4;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  sram_ctrl_burst_if #(.ADDR_W(AW), .DATA_W(DW), .LEN_W(LW)) u_if ();

  wire  [DW-1:0] sram_dq;
  logic [AW-1:0] sram_addr;
  logic          cs_n;
  logic          oe_n;
  logic          we_n;
  logic [1:0]    be_n;

  sram_ctrl_burst #(
    .ADDR_W(AW), .DATA_W(DW), .LEN_W(LW),
    .POWERUP_CYC(8), .RD_CYC(3), .WR_CYC(3), .TURN_CYC(1)
  ) dut (
    .i_clk(clk),
    .reset(reset),
    .bus(u_if),
    .o_sram_addr(sram_addr),
    .io_sram_dq(sram_dq),
    .o_sram_cs_n(cs_n),
    .o_sram_oe_n(oe_n),
    .o_sram_we_n(we_n),
    .o_sram_be_n(be_n)
  );

  for (genvar gi = 0; gi < DW; gi++) begin : g_pd
    pulldown (sram_dq[gi]);
  end

  // SRAM model: 256 words indexed by the low address byte
  logic [15:0] mem [0:255] = '{default: 16'h0000};
  assign sram_dq = (!cs_n && !oe_n && we_n) ? mem[sram_addr[7:0]] : 16'hzzzz;

  int cyc = 0;
  int n_mem_wr = 0;
  int n_done = 0;
  int we_run = 0;
  int last_we_len = 0;
  int n_chk = 0;
  int n_fail = 0;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (!cs_n && !we_n) begin
      n_mem_wr <= n_mem_wr + 1;
      if (!be_n[0]) mem[sram_addr[7:0]][7:0]  <= sram_dq[7:0];
      if (!be_n[1]) mem[sram_addr[7:0]][15:8] <= sram_dq[15:8];
    end
    if (u_if.o_wr_done) n_done <= n_done + 1;
    if (!we_n) begin
      we_run <= we_run + 1;
    end else if (we_run != 0) begin
      last_we_len <= we_run;
      we_run <= 0;
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_idle(input string tag);
    int k = 0;
    while (!u_if.o_cmd_ready && k < 100) begin
      step(1);
      k++;
    end
    chk(tag, u_if.o_cmd_ready, 1'b1);
  endtask

  // Presents a command and returns at the negedge just after the accept edge
  task automatic start_cmd(input logic wr, input logic [AW-1:0] a, input logic [LW-1:0] len,
                           input logic [1:0] be);
    u_if.i_cmd_wr    = wr;
    u_if.i_cmd_addr  = a;
    u_if.i_cmd_len   = len;
    u_if.i_cmd_be    = be;
    u_if.i_cmd_valid = 1'b1;
    wait_idle("cmd_ready_wait");
    step(1);
    u_if.i_cmd_valid = 1'b0;
  endtask

  task automatic write_burst(input logic [AW-1:0] a, input logic [LW-1:0] len, input logic [1:0] be,
                             input logic [15:0] d0, input logic [15:0] d1,
                             input logic [15:0] d2, input logic [15:0] d3);
    logic [15:0] dw [4];
    int k;
    dw[0] = d0; dw[1] = d1; dw[2] = d2; dw[3] = d3;
    u_if.i_wr_data  = d0;
    u_if.i_wr_valid = 1'b1;
    start_cmd(1'b1, a, len, be);
    for (int w = 0; w <= int'(len); w++) begin
      u_if.i_wr_data  = dw[w];
      u_if.i_wr_valid = 1'b1;
      k = 0;
      while (!u_if.o_wr_ready && k < 100) begin
        step(1);
        k++;
      end
      chk("wb_wr_ready", u_if.o_wr_ready, 1'b1);
      step(1);
      u_if.i_wr_valid = 1'b0;
    end
    wait_idle("wb_idle");
  endtask

  initial begin
    int d0;
    int w0;
    logic [AW-1:0] ea;
    logic [15:0] rdw [4];
    u_if.i_cmd_valid = 1'b0;
    u_if.i_cmd_wr    = 1'b0;
    u_if.i_cmd_addr  = '0;
    u_if.i_cmd_len   = '0;
    u_if.i_cmd_be    = '0;
    u_if.i_wr_data   = '0;
    u_if.i_wr_valid  = 1'b0;

    // 1: reset values and power-up wait
    step(3);
    chk("rst_cs_n", cs_n, 1'b1);
    chk("rst_oe_n", oe_n, 1'b1);
    chk("rst_we_n", we_n, 1'b1);
    chk("rst_be_n", be_n, 2'b11);
    chk("rst_addr", sram_addr, 21'h0);
    chk("rst_dq", sram_dq, 16'h0000);
    chk("rst_cmd_ready", u_if.o_cmd_ready, 1'b0);
    chk("rst_busy", u_if.o_busy, 1'b1);
    chk("rst_rd_data", u_if.o_rd_data, 16'h0000);
    chk("rst_rd_valid", u_if.o_rd_valid, 1'b0);
    reset = 1'b1;
    step(7);
    chk("init7_ready", u_if.o_cmd_ready, 1'b0);
    chk("init7_cs_n", cs_n, 1'b1);
    chk("init7_dq", sram_dq, 16'h0000);
    step(1);
    chk("init8_ready", u_if.o_cmd_ready, 1'b1);
    chk("init8_busy", u_if.o_busy, 1'b0);

    // 2: single write then read-back
    d0 = n_done;
    u_if.i_wr_data  = 16'hA55A;
    u_if.i_wr_valid = 1'b1;
    start_cmd(1'b1, 21'h1ABCD, 4'd0, 2'b11);
    chk("w_m0_wr_ready", u_if.o_wr_ready, 1'b1);
    chk("w_m0_cs_n", cs_n, 1'b0);
    chk("w_m0_we_n", we_n, 1'b1);
    chk("w_m0_dq", sram_dq, 16'h0000);
    step(1);
    u_if.i_wr_valid = 1'b0;
    chk("w_setup_dq", sram_dq, 16'hA55A);
    chk("w_setup_we_n", we_n, 1'b1);
    chk("w_setup_addr", sram_addr, 21'h1ABCD);
    for (int m = 2; m <= 4; m++) begin
      step(1);
      chk($sformatf("w_pulse%0d_we_n", m), we_n, 1'b0);
      chk($sformatf("w_pulse%0d_be_n", m), be_n, 2'b00);
      chk($sformatf("w_pulse%0d_oe_n", m), oe_n, 1'b1);
    end
    step(1);
    chk("w_hold_we_n", we_n, 1'b1);
    chk("w_hold_dq", sram_dq, 16'hA55A);
    step(1);
    chk("w_done_pulse", u_if.o_wr_done, 1'b1);
    chk("w_turn_cs_n", cs_n, 1'b1);
    chk("w_turn_dq", sram_dq, 16'h0000);
    step(1);
    chk("w_done_low", u_if.o_wr_done, 1'b0);
    chk("w_idle_ready", u_if.o_cmd_ready, 1'b1);
    chk("w_mem", mem[8'hCD], 16'hA55A);
    chk("w_done_count", n_done, d0 + 1);

    start_cmd(1'b0, 21'h1ABCD, 4'd0, 2'b00);
    chk("r_m0_cs_n", cs_n, 1'b0);
    chk("r_m0_oe_n", oe_n, 1'b0);
    chk("r_m0_be_n", be_n, 2'b00);
    chk("r_m0_we_n", we_n, 1'b1);
    step(2);
    chk("r_m2_valid", u_if.o_rd_valid, 1'b0);
    step(1);
    chk("r_m3_valid", u_if.o_rd_valid, 1'b1);
    chk("r_m3_data", u_if.o_rd_data, 16'hA55A);
    chk("r_m3_cs_n", cs_n, 1'b1);
    step(1);
    chk("r_m4_valid", u_if.o_rd_valid, 1'b0);
    chk("r_m4_ready", u_if.o_cmd_ready, 1'b1);

    // 3: partial byte write over 0xFFFF
    write_burst(21'h00010, 4'd0, 2'b11, 16'hFFFF, 16'h0, 16'h0, 16'h0);
    chk("pb_pre", mem[8'h10], 16'hFFFF);
    u_if.i_wr_data  = 16'h1234;
    u_if.i_wr_valid = 1'b1;
    start_cmd(1'b1, 21'h00010, 4'd0, 2'b01);
    step(1);
    u_if.i_wr_valid = 1'b0;
    chk("pb_setup_be_n", be_n, 2'b11);
    for (int m = 2; m <= 4; m++) begin
      step(1);
      chk($sformatf("pb_pulse%0d_be_n", m), be_n, 2'b10);
    end
    step(1);
    chk("pb_hold_be_n", be_n, 2'b11);
    wait_idle("pb_idle");
    chk("pb_mem", mem[8'h10], 16'hFF34);
    chk("pb_we_len", last_we_len, 3);

    // 4: wrapping burst write, then wrapping burst read
    write_burst(21'h1FFFFE, 4'd3, 2'b11, 16'hC001, 16'hC002, 16'hC003, 16'hC004);
    chk("bw_mem_fe", mem[8'hFE], 16'hC001);
    chk("bw_mem_ff", mem[8'hFF], 16'hC002);
    chk("bw_mem_00", mem[8'h00], 16'hC003);
    chk("bw_mem_01", mem[8'h01], 16'hC004);
    rdw[0] = 16'hC001; rdw[1] = 16'hC002; rdw[2] = 16'hC003; rdw[3] = 16'hC004;
    start_cmd(1'b0, 21'h1FFFFE, 4'd3, 2'b00);
    for (int m = 0; m <= 12; m++) begin
      if (m > 0) step(1);
      ea = 21'h1FFFFE + 21'(m / 3);
      if (m < 12) begin
        chk($sformatf("br_m%0d_addr", m), sram_addr, ea);
        chk($sformatf("br_m%0d_cs_n", m), cs_n, 1'b0);
      end else begin
        chk("br_m12_cs_n", cs_n, 1'b1);
      end
      chk($sformatf("br_m%0d_valid", m), u_if.o_rd_valid, (m > 0 && m % 3 == 0));
      if (m > 0 && m % 3 == 0) begin
        chk($sformatf("br_m%0d_data", m), u_if.o_rd_data, rdw[m / 3 - 1]);
      end
    end
    step(1);
    chk("br_idle", u_if.o_cmd_ready, 1'b1);

    // 5: two-word write with a 5-cycle data gap
    d0 = n_done;
    u_if.i_wr_data  = 16'h1111;
    u_if.i_wr_valid = 1'b1;
    start_cmd(1'b1, 21'h00020, 4'd1, 2'b11);
    step(1);
    u_if.i_wr_valid = 1'b0;
    step(5);
    w0 = n_mem_wr;
    chk("gap_m6_wr_ready", u_if.o_wr_ready, 1'b1);
    for (int m = 6; m <= 10; m++) begin
      if (m > 6) step(1);
      chk($sformatf("gap_m%0d_we_n", m), we_n, 1'b1);
      chk($sformatf("gap_m%0d_cs_n", m), cs_n, 1'b0);
    end
    chk("gap_no_write", n_mem_wr, w0);
    chk("gap_no_done", n_done, d0);
    step(1);
    u_if.i_wr_data  = 16'h2222;
    u_if.i_wr_valid = 1'b1;
    step(1);
    u_if.i_wr_valid = 1'b0;
    chk("gap_w2_dq", sram_dq, 16'h2222);
    chk("gap_w2_addr", sram_addr, 21'h00021);
    step(5);
    chk("gap_done", u_if.o_wr_done, 1'b1);
    step(2);
    chk("gap_done_count", n_done, d0 + 1);
    chk("gap_mem0", mem[8'h20], 16'h1111);
    chk("gap_mem1", mem[8'h21], 16'h2222);

    // 6: reset in the second WE-pulse cycle
    u_if.i_wr_data  = 16'h5A5A;
    u_if.i_wr_valid = 1'b1;
    start_cmd(1'b1, 21'h00030, 4'd0, 2'b11);
    step(1);
    u_if.i_wr_valid = 1'b0;
    step(2);
    chk("ar_pulse_we_n", we_n, 1'b0);
    reset = 1'b0;
    #1;
    chk("ar_we_n", we_n, 1'b1);
    chk("ar_cs_n", cs_n, 1'b1);
    chk("ar_be_n", be_n, 2'b11);
    chk("ar_dq", sram_dq, 16'h0000);
    chk("ar_busy", u_if.o_busy, 1'b1);
    chk("ar_wr_ready", u_if.o_wr_ready, 1'b0);
    chk("ar_mem_whole", (mem[8'h30] === 16'h0000) || (mem[8'h30] === 16'h5A5A), 1'b1);
    step(2);
    reset = 1'b1;
    step(7);
    chk("ar_init7_ready", u_if.o_cmd_ready, 1'b0);
    chk("ar_init7_we_n", we_n, 1'b1);
    step(1);
    chk("ar_init8_ready", u_if.o_cmd_ready, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end
endmodule
